uart_rx_cfg: RTL and testbench

Parametrised UART receiver that replaces the fixed 8N1 receiver in the UART protocol path. It supports a configurable data width, optional odd/even parity and one or two stop bits. The input is synchronised and each bit is taken by a 3-sample majority vote at mid-bit. Framing errors, parity errors and line-break conditions are reported alongside each received word on a single-cycle valid strobe.

---
 rtl/uart_rx_cfg.sv | 155 +++++++++++++++
 tb/tb_uart_rx_cfg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, optional odd/even parity, 1-2 stop bits.
// Mid-bit 3-sample majority vote; parity, framing and break flags reported per word.
`timescale 1ns/1ps
module uart_rx_cfg #(
   parameter int CLOCK_FREQ = 50000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_rxd,
   input  logic                 uart_rx_en,
   output logic                 uart_rx_valid,
   output logic [DATA_BITS-1:0] uart_rx_data,
   output logic                 uart_rx_parity_err,
   output logic                 uart_rx_frame_err,
   output logic                 uart_rx_break
);

   localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF       = BIT_CYCLES / 2;
   localparam int CW         = $clog2(BIT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
   } state_t;

   state_t                 r_state;
   logic [1:0]             r_sync;
   logic                   r_rxs_q;
   logic [CW-1:0]          r_cnt;
   logic [3:0]             r_bit;
   logic                   r_s0;
   logic                   r_s1;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_par;
   logic                   r_ferr;
   logic                   r_allz;

   logic w_rxs;
   logic w_vote;
   logic w_mid;
   logic w_end;
   logic w_ferr_n;
   logic w_allz_n;
   logic w_par_x;
   logic w_perr;

   assign w_rxs    = r_sync[1];
   assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
   assign w_mid    = (r_cnt == CW'(HALF + 1));
   assign w_end    = (r_cnt == CW'(BIT_CYCLES - 1));
   assign w_ferr_n = r_ferr | ~w_vote;
   assign w_allz_n = r_allz & ~w_vote;
   assign w_par_x  = ^{r_shift, r_par};
   assign w_perr   = (PARITY == 1) ? ~w_par_x :
                     (PARITY == 2) ?  w_par_x : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= 2'b11;
      else     r_sync <= {r_sync[0], uart_rxd};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state            <= S_IDLE;
         r_rxs_q            <= 1'b1;
         r_cnt              <= '0;
         r_bit              <= '0;
         r_s0               <= 1'b1;
         r_s1               <= 1'b1;
         r_shift            <= '0;
         r_par              <= 1'b0;
         r_ferr             <= 1'b0;
         r_allz             <= 1'b0;
         uart_rx_valid      <= 1'b0;
         uart_rx_data       <= '0;
         uart_rx_parity_err <= 1'b0;
         uart_rx_frame_err  <= 1'b0;
         uart_rx_break      <= 1'b0;
      end else begin
         r_rxs_q       <= w_rxs;
         uart_rx_valid <= 1'b0;
         r_cnt         <= w_end ? '0 : r_cnt + CW'(1);
         if (r_cnt == CW'(HALF - 1)) r_s0 <= w_rxs;
         if (r_cnt == CW'(HALF))     r_s1 <= w_rxs;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (uart_rx_en && r_rxs_q && !w_rxs) r_state <= S_START;
            end
            S_START: begin
               if (w_mid && w_vote) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (w_end) begin
                  r_state <= S_DATA;
                  r_bit   <= '0;
                  r_allz  <= 1'b1;
                  r_ferr  <= 1'b0;
                  r_par   <= 1'b0;
               end
            end
            S_DATA: begin
               if (w_mid) begin
                  r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                  r_allz  <= w_allz_n;
               end
               if (w_end) begin
                  if (r_bit == 4'(DATA_BITS - 1)) begin
                     r_bit   <= '0;
                     r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     r_bit <= r_bit + 4'd1;
                  end
               end
            end
            S_PARITY: begin
               if (w_mid) begin
                  r_par  <= w_vote;
                  r_allz <= w_allz_n;
               end
               if (w_end) r_state <= S_STOP;
            end
            S_STOP: begin
               // Last stop bit completes at its vote so a back-to-back start can be caught.
               if (w_mid) begin
                  if (r_bit == 4'(STOP_BITS - 1)) begin
                     uart_rx_valid      <= 1'b1;
                     uart_rx_data       <= r_shift;
                     uart_rx_parity_err <= w_perr;
                     uart_rx_frame_err  <= w_ferr_n;
                     uart_rx_break      <= w_allz_n;
                     r_state            <= w_allz_n ? S_BRKWAIT : S_IDLE;
                     r_cnt              <= '0;
                  end else begin
                     r_ferr <= w_ferr_n;
                     r_allz <= w_allz_n;
                  end
               end else if (w_end) begin
                  r_bit <= r_bit + 4'd1;
               end
            end
            S_BRKWAIT: begin
               r_cnt <= '0;
               if (w_rxs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomised bench for uart_rx_cfg: two configurations (8E1 and 9N2)
// compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

   localparam int CF   = 2000;
   localparam int BR   = 100;
   localparam int BC   = CF / BR;
   localparam int HALF = BC / 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd_a, en_a, rxd_b, en_b;
   logic       va, pea, fea, ba;
   logic [7:0] da;
   logic       vb, peb, feb, bb;
   logic [8:0] db;

   uart_rx_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .uart_rxd(rxd_a), .uart_rx_en(en_a),
      .uart_rx_valid(va), .uart_rx_data(da), .uart_rx_parity_err(pea),
      .uart_rx_frame_err(fea), .uart_rx_break(ba));

   uart_rx_cfg #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(9),
                 .PARITY(0), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .uart_rxd(rxd_b), .uart_rx_en(en_b),
      .uart_rx_valid(vb), .uart_rx_data(db), .uart_rx_parity_err(peb),
      .uart_rx_frame_err(feb), .uart_rx_break(bb));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [8:0] d;
      bit         pe, fe, brk;
      int         t;
   } rec_t;

   rec_t qa[$];
   rec_t qb[$];

   always @(negedge clk) begin : mon
      rec_t r;
      if (va === 1'b1) begin
         r.d = {1'b0, da}; r.pe = pea; r.fe = fea; r.brk = ba; r.t = cyc;
         qa.push_back(r);
      end
      if (vb === 1'b1) begin
         r.d = db; r.pe = peb; r.fe = feb; r.brk = bb; r.t = cyc;
         qb.push_back(r);
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Per-instance frame formats: 0 = 8 data, even parity, 1 stop; 1 = 9 data, none, 2 stop.
   function automatic int nd_of(input int w); return w ? 9 : 8; endfunction
   function automatic int pm_of(input int w); return w ? 0 : 2; endfunction
   function automatic int ns_of(input int w); return w ? 2 : 1; endfunction

   task automatic mk_frame(input int w, input logic [8:0] d, input bit pb,
                           input bit [1:0] st, output bit q[$]);
      q.delete();
      q.push_back(1'b0);
      for (int i = 0; i < nd_of(w); i++) q.push_back(d[i]);
      if (pm_of(w) != 0) q.push_back(pb);
      for (int i = 0; i < ns_of(w); i++) q.push_back(st[i]);
   endtask

   task automatic model(input int w, input logic [8:0] d, input bit pb,
                        input bit [1:0] st, output logic [8:0] ed,
                        output bit pe, output bit fe, output bit brk);
      logic [9:0] m;
      int pm, ns;
      pm = pm_of(w);
      ns = ns_of(w);
      m  = (10'd1 << nd_of(w)) - 10'd1;
      ed = d & m[8:0];
      pe = (pm == 0) ? 1'b0 : (pm == 1) ? ~(^ed ^ pb) : (^ed ^ pb);
      fe = !st[0] || (ns == 2 && !st[1]);
      brk = (ed == 0) && (pm == 0 || !pb) && !st[0] && (ns == 1 || !st[1]);
   endtask

   task automatic set_line(input int w, input bit v);
      if (w == 0) rxd_a = v;
      else        rxd_b = v;
   endtask

   task automatic drive(input int w, input bit q[$], output int t0);
      @(negedge clk);
      t0 = cyc;
      foreach (q[i]) begin
         set_line(w, q[i]);
         repeat (BC) @(negedge clk);
      end
   endtask

   task automatic idle(input int w, input int n);
      set_line(w, 1'b1);
      repeat (n) @(negedge clk);
   endtask

   task automatic verify(input string tag, input int w, input logic [8:0] ed,
                         input bit pe, input bit fe, input bit brk, input int t0);
      rec_t r;
      int   k, lat;
      k = (nd_of(w) + (pm_of(w) != 0 ? 1 : 0) + ns_of(w)) * BC + HALF + 5;
      if ((w == 0 ? qa.size() : qb.size()) == 0) return;
      r = (w == 0) ? qa.pop_front() : qb.pop_front();
      chk({tag, ".data"}, r.d, ed);
      chk({tag, ".perr"}, r.pe, pe);
      chk({tag, ".ferr"}, r.fe, fe);
      chk({tag, ".brk"}, r.brk, brk);
      lat = r.t - t0;
      chk({tag, ".lat"}, (lat >= k - 2 && lat <= k + 2) ? k : lat, k);
   endtask

   task automatic xfer(input string tag, input int w, input logic [8:0] d,
                       input bit pb, input bit [1:0] st, input int gap);
      bit q[$];
      int t0;
      logic [8:0] ed;
      bit pe, fe, brk;
      mk_frame(w, d, pb, st, q);
      drive(w, q, t0);
      idle(w, gap);
      model(w, d, pb, st, ed, pe, fe, brk);
      chk({tag, ".n"}, (w == 0) ? qa.size() : qb.size(), 1);
      verify(tag, w, ed, pe, fe, brk, t0);
      if (w == 0) qa.delete();
      else        qb.delete();
   endtask

   initial begin : main
      bit q[$];
      bit q2[$];
      int t0;
      logic [8:0] d, ed;
      bit pe, fe, brk, pb;
      bit [1:0] st;

      rst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.va", va, 0);
      chk("rst.da", da, 0);
      chk("rst.flags_a", {pea, fea, ba}, 0);
      chk("rst.vb", vb, 0);
      chk("rst.db", db, 0);
      chk("rst.flags_b", {peb, feb, bb}, 0);
      rst = 1'b0;
      idle(0, 2 * BC);

      xfer("a_A5", 0, 9'h0A5, ^8'hA5, 2'b11, 2 * BC);
      xfer("a_07_bad", 0, 9'h007, 1'b0, 2'b11, 2 * BC);
      xfer("a_07_ok", 0, 9'h007, 1'b1, 2'b11, 2 * BC);
      xfer("a_3C_stop0", 0, 9'h03C, ^8'h3C, 2'b10, 2 * BC);
      xfer("a_81", 0, 9'h081, ^8'h81, 2'b11, 2 * BC);

      @(negedge clk);
      rxd_a = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      idle(0, 2 * BC);
      chk("glitch.n", qa.size(), 0);
      xfer("a_5A", 0, 9'h05A, ^8'h5A, 2'b11, 2 * BC);

      @(negedge clk);
      t0 = cyc;
      rxd_a = 1'b0;
      repeat (12 * BC) @(negedge clk);
      chk("brk.n", qa.size(), 1);
      model(0, 9'h000, 1'b0, 2'b00, ed, pe, fe, brk);
      verify("brk", 0, ed, pe, fe, brk, t0);
      idle(0, 2 * BC);
      chk("brk.after", qa.size(), 0);
      xfer("a_FF", 0, 9'h0FF, ^8'hFF, 2'b11, 2 * BC);

      en_a = 1'b0;
      mk_frame(0, 9'h033, 1'b0, 2'b11, q);
      drive(0, q, t0);
      idle(0, 2 * BC);
      chk("en_off.n", qa.size(), 0);
      en_a = 1'b1;
      mk_frame(0, 9'h0C6, ^8'hC6, 2'b11, q);
      fork
         drive(0, q, t0);
         begin
            repeat (3 * BC) @(negedge clk);
            en_a = 1'b0;
         end
      join
      idle(0, 2 * BC);
      chk("en_mid.n", qa.size(), 1);
      model(0, 9'h0C6, ^8'hC6, 2'b11, ed, pe, fe, brk);
      verify("en_mid", 0, ed, pe, fe, brk, t0);
      en_a = 1'b1;

      for (int i = 0; i < 8; i++) begin
         d  = 9'($urandom_range(0, 255));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'b10;
         xfer($sformatf("a_rnd%0d", i), 0, d, pb, st, $urandom_range(1, 2 * BC));
      end

      mk_frame(1, 9'h1A3, 1'b0, 2'b11, q);
      mk_frame(1, 9'h055, 1'b0, 2'b11, q2);
      q = {q, q2};
      drive(1, q, t0);
      idle(1, 2 * BC);
      chk("b2b.n", qb.size(), 2);
      verify("b2b0", 1, 9'h1A3, 1'b0, 1'b0, 1'b0, t0);
      verify("b2b1", 1, 9'h055, 1'b0, 1'b0, 1'b0, t0 + 12 * BC);

      for (int i = 0; i < 6; i++) begin
         d  = 9'($urandom_range(0, 511));
         st[0] = ($urandom_range(0, 3) != 0);
         st[1] = ($urandom_range(0, 3) != 0);
         xfer($sformatf("b_rnd%0d", i), 1, d, 1'b0, st, $urandom_range(1, 2 * BC));
      end
      xfer("b_055", 1, 9'h055, 1'b0, 2'b11, 2 * BC);

      @(negedge clk);
      rxd_b = 1'b0;
      repeat (BC) @(negedge clk);
      rxd_b = 1'b1;
      repeat (BC) @(negedge clk);
      rxd_b = 1'b0;
      repeat (BC) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstmid.vb", vb, 0);
      chk("rstmid.db", db, 0);
      chk("rstmid.flags", {peb, feb, bb}, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(1, 10 * BC);
      chk("rstmid.n", qb.size(), 0);
      chk("rstmid.db_hold", db, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
